// File: rtl/ftransform_wht_if.sv
// Handshake bundle between the forward DCT DC stream, the luma WHT and the quantiser.
// The master drives DC samples in; the slave returns the transformed coefficients.
interface ftransform_wht_if #(
    parameter int DW = 16
);
    logic              start;
    logic              dc_valid;
    logic [DW-1:0]     dc_in;
    logic [DW*16-1:0]  out;
    logic              done;
    logic              busy;

    modport master (output start, dc_valid, dc_in, input out, done, busy);
    modport slave  (input start, dc_valid, dc_in, output out, done, busy);
endinterface

// File: rtl/ftransform_wht.sv
// Forward 4x4 Walsh-Hadamard transform of the 16 luma DC coefficients of a macroblock.
// Collects one sample per cycle, then runs a horizontal and a vertical pass, one register each.
module ftransform_wht #(
    parameter int BLOCK_SIZE = 4,
    parameter int DW         = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ftransform_wht_if.slave bus
);
    localparam int NC = BLOCK_SIZE * BLOCK_SIZE;

    logic [3:0]           count;
    logic [3:0]           wr_idx;
    logic                 last_sample;
    logic                 s1_valid;
    logic                 s2_valid;
    logic signed [DW-1:0] dc       [NC];
    logic signed [17:0]   tmp      [NC];
    logic signed [17:0]   tmp_next [NC];
    logic [DW*NC-1:0]     out_next;

    // start forces the current sample (if any) to index 0.
    assign wr_idx      = bus.start ? 4'd0 : count;
    assign last_sample = bus.dc_valid && (wr_idx == 4'd15);
    assign bus.busy    = (count != 4'd0) | s1_valid | s2_valid;

    // Horizontal pass over each row of the collected buffer.
    logic signed [17:0] h0, h1, h2, h3, ha0, ha1, ha2, ha3;
    always_comb begin
        h0 = '0; h1 = '0; h2 = '0; h3 = '0;
        ha0 = '0; ha1 = '0; ha2 = '0; ha3 = '0;
        for (int i = 0; i < NC; i++) tmp_next[i] = '0;
        for (int r = 0; r < 4; r++) begin
            h0  = dc[4*r];
            h1  = dc[4*r+1];
            h2  = dc[4*r+2];
            h3  = dc[4*r+3];
            ha0 = h0 + h2;
            ha1 = h1 + h3;
            ha2 = h1 - h3;
            ha3 = h0 - h2;
            tmp_next[4*r]   = ha0 + ha1;
            tmp_next[4*r+1] = ha3 + ha2;
            tmp_next[4*r+2] = ha3 - ha2;
            tmp_next[4*r+3] = ha0 - ha1;
        end
    end

    // Vertical pass; the final >>>1 floors toward minus infinity with no rounding offset.
    logic signed [19:0] v0, v1, v2, v3, va0, va1, va2, va3, vb0, vb1, vb2, vb3;
    logic signed [19:0] sh0, sh1, sh2, sh3;
    always_comb begin
        v0 = '0; v1 = '0; v2 = '0; v3 = '0;
        va0 = '0; va1 = '0; va2 = '0; va3 = '0;
        vb0 = '0; vb1 = '0; vb2 = '0; vb3 = '0;
        sh0 = '0; sh1 = '0; sh2 = '0; sh3 = '0;
        out_next = '0;
        for (int c = 0; c < 4; c++) begin
            v0  = tmp[c];
            v1  = tmp[4+c];
            v2  = tmp[8+c];
            v3  = tmp[12+c];
            va0 = v0 + v2;
            va1 = v1 + v3;
            va2 = v1 - v3;
            va3 = v0 - v2;
            vb0 = va0 + va1;
            vb1 = va3 + va2;
            vb2 = va3 - va2;
            vb3 = va0 - va1;
            sh0 = vb0 >>> 1;
            sh1 = vb1 >>> 1;
            sh2 = vb2 >>> 1;
            sh3 = vb3 >>> 1;
            out_next[DW*c      +: DW] = sh0[DW-1:0];
            out_next[DW*(4+c)  +: DW] = sh1[DW-1:0];
            out_next[DW*(8+c)  +: DW] = sh2[DW-1:0];
            out_next[DW*(12+c) +: DW] = sh3[DW-1:0];
        end
    end

    // NOTE: the sample buffer and stage-1 array carry no reset; their contents are only
    // consumed behind count/valid flags, which are reset, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (bus.dc_valid) dc[wr_idx] <= bus.dc_in;
        if (s1_valid)     tmp <= tmp_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 4'd0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            bus.done <= 1'b0;
            bus.out  <= '0;
        end else begin
            if (bus.dc_valid)   count <= wr_idx + 4'd1;
            else if (bus.start) count <= 4'd0;
            s1_valid <= last_sample;
            s2_valid <= s1_valid;
            bus.done <= s2_valid;
            if (s2_valid) bus.out <= out_next;
        end
    end
endmodule

// File: tb/tb_ftransform_wht.sv
// Directed bench for ftransform_wht: reset abort, flat/impulse blocks, back-to-back and resync.
// Random blocks are compared against a matrix-form Hadamard model.
module tb_ftransform_wht;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ftransform_wht_if #(.DW(16)) bus ();
    ftransform_wht #(.BLOCK_SIZE(4), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef int blk_t [16];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [255:0] pack(input blk_t e);
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < 16; k++) p[16*k +: 16] = 16'(e[k]);
        return p;
    endfunction

    // out[r][c] = floor((H * X * H^T)[r][c] / 2), H in the VP8 WHT row order.
    function automatic blk_t model(input blk_t x);
        int   h [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
        blk_t y;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                int s = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) s += h[r][i] * h[c][j] * x[4*i+j];
                y[4*r+c] = s >>> 1;
            end
        return y;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int k = 0; k < 16; k++) b[k] = int'($urandom_range(0, 4095)) - 2048;
        return b;
    endfunction

    task automatic feed(input int v, input logic s);
        @(negedge clk);
        bus.dc_valid = 1'b1;
        bus.dc_in    = 16'(v);
        bus.start    = s;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.dc_valid = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic feed_block(input blk_t b, input logic first_start);
        for (int k = 0; k < 16; k++) feed(b[k], (k == 0) ? first_start : 1'b0);
        idle();
    endtask

    // Entered at the first falling edge after the last sample's rising edge.
    task automatic wait_done(input string name, input logic [255:0] exp);
        int lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 3) begin
            n_err++;
            $display("FAIL %s latency: got %0d, want 3", name, lat);
        end
        n_cmp++;
        if (bus.out !== exp) begin
            n_err++;
            $display("FAIL %s out: got %h, want %h", name, bus.out, exp);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: got %b, want 0", name, bus.done);
        end
    endtask

    task automatic test_reset();
        blk_t b = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dc_valid = 1'b0; bus.dc_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, want 0", bus.done); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, want 0", bus.busy); end
        n_cmp++;
        if (bus.out !== '0) begin n_err++; $display("FAIL reset_out: got %h, want 0", bus.out); end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) feed(7, 1'b0);
        idle();
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL partial_busy: got %b, want 1", bus.busy); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, want 0", bus.busy); end
        feed_block(b, 1'b0);
        n_cmp++;
        if (bus.out !== '0) begin n_err++; $display("FAIL abort_out: got %h, want 0", bus.out); end
        wait_done("after_reset", {16{16'd50}});
    endtask

    task automatic test_dc_flat();
        blk_t b = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
        blk_t e = '{64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        feed_block(b, 1'b0);
        wait_done("dc_flat", pack(e));
    endtask

    task automatic test_impulse();
        blk_t b = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        feed_block(b, 1'b0);
        wait_done("impulse_pos", {16{16'd50}});
        b[0] = -3;
        feed_block(b, 1'b0);
        wait_done("impulse_neg", {16{16'hFFFE}});
    endtask

    task automatic test_offcentre();
        blk_t b = '{0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        blk_t e = '{5, 5, -5, -5, 5, 5, -5, -5, -5, -5, 5, 5, -5, -5, 5, 5};
        feed_block(b, 1'b0);
        wait_done("offcentre", pack(e));
    endtask

    task automatic test_back_to_back();
        blk_t ea = '{64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                logic exp_done, exp_busy;
                exp_done = (c == 18) || (c == 34);
                exp_busy = (c <= 33);
                n_cmp++;
                if (bus.done !== exp_done) begin
                    n_err++;
                    $display("FAIL b2b_done c=%0d: got %b, want %b", c, bus.done, exp_done);
                end
                n_cmp++;
                if (bus.busy !== exp_busy) begin
                    n_err++;
                    $display("FAIL b2b_busy c=%0d: got %b, want %b", c, bus.busy, exp_busy);
                end
                if (c == 18) begin
                    n_cmp++;
                    if (bus.out !== pack(ea)) begin
                        n_err++;
                        $display("FAIL b2b_out_a: got %h, want %h", bus.out, pack(ea));
                    end
                end
                if (c == 34) begin
                    n_cmp++;
                    if (bus.out !== {16{16'd50}}) begin
                        n_err++;
                        $display("FAIL b2b_out_b: got %h, want %h", bus.out, {16{16'd50}});
                    end
                end
            end
            bus.start    = 1'b0;
            bus.dc_valid = (c < 32);
            bus.dc_in    = (c < 16) ? 16'd8 : (c == 16) ? 16'd100 : 16'd0;
        end
        bus.dc_valid = 1'b0;
    endtask

    task automatic test_start_resync();
        blk_t b;
        for (int k = 0; k < 5; k++) feed(int'($urandom_range(0, 4095)) - 2048, 1'b0);
        b = rand_blk();
        feed_block(b, 1'b1);
        wait_done("resync_with_sample", pack(model(b)));
        for (int k = 0; k < 7; k++) feed(int'($urandom_range(0, 4095)) - 2048, 1'b0);
        @(negedge clk);
        bus.dc_valid = 1'b0;
        bus.start    = 1'b1;
        idle();
        b = rand_blk();
        feed_block(b, 1'b0);
        wait_done("resync_start_only", pack(model(b)));
        for (int n = 0; n < 3; n++) begin
            b = rand_blk();
            feed_block(b, 1'b0);
            wait_done("random_block", pack(model(b)));
        end
    endtask

    initial begin
        test_reset();
        test_dc_flat();
        test_impulse();
        test_offcentre();
        test_back_to_back();
        test_start_resync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
